// File: rtl/ntt_ctrl.sv
// Sequencer for an in-place radix-2 Cooley-Tukey forward NTT (N=16, q=65537).
// Issues one butterfly per handshake and drains the butterfly pipeline between stages.
module ntt_ctrl #(
  parameter int N      = 16,
  parameter int LOGN   = 4,
  parameter int BF_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    bf_valid,
  input  logic                    bf_ready,
  output logic [LOGN-1:0]         addr_a,
  output logic [LOGN-1:0]         addr_b,
  output logic [LOGN-1:0]         psi_addr,
  output logic [$clog2(LOGN)-1:0] stage,
  output logic                    bf_last
);

  localparam int SW = $clog2(LOGN);
  localparam int KW = LOGN - 1;
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   s, s_nx;
  logic [KW-1:0]   k, k_nx;
  logic [DW-1:0]   dcnt, dcnt_nx;
  logic [LOGN-1:0] t, grp, ofs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      k     <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      s     <= s_nx;
      k     <= k_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // Span t, group i and offset j of butterfly k within stage s.
  always_comb begin
    t   = LOGN'(N >> (int'(s) + 1));
    grp = LOGN'(k) >> (LOGN - 1 - int'(s));
    ofs = LOGN'(k) & (t - 1'b1);
  end

  assign stage = s;

  always_comb begin
    state_nx = state;
    s_nx     = s;
    k_nx     = k;
    dcnt_nx  = dcnt;
    busy     = 1'b0;
    done     = 1'b0;
    bf_valid = 1'b0;
    addr_a   = '0;
    addr_b   = '0;
    psi_addr = '0;
    bf_last  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ISSUE;
          s_nx     = '0;
          k_nx     = '0;
        end
      end
      ISSUE: begin
        busy     = 1'b1;
        bf_valid = 1'b1;
        addr_a   = ((grp * t) << 1) + ofs;
        addr_b   = addr_a + t;
        psi_addr = (LOGN'(1) << s) + grp;
        bf_last  = (s == SW'(LOGN - 1)) && (k == KW'(N / 2 - 1));
        if (bf_ready) begin
          if (k == KW'(N / 2 - 1)) begin
            state_nx = DRAIN;
            dcnt_nx  = '0;
          end else begin
            k_nx = k + 1'b1;
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (dcnt == DW'(BF_LAT - 1)) begin
          if (s == SW'(LOGN - 1)) begin
            state_nx = DONE;
          end else begin
            state_nx = ISSUE;
            s_nx     = s + 1'b1;
            k_nx     = '0;
          end
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
        s_nx     = '0;
        k_nx     = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
